// File: rtl/wb_regfile.sv
// Write-back register file: commits W-stage results into the 32x32 GPR
// array, serves two combinational D-stage read ports with optional W-to-D
// bypass, and produces a registered commit trace plus a commit counter.
module wb_regfile #(
    parameter int          BYPASS   = 1,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we_w,
    input  logic [31:0] pc_w,
    input  logic [4:0]  dst_w,
    input  logic [31:0] wd_w,
    input  logic [2:0]  tnew_w,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic        trace_valid,
    output logic [31:0] trace_pc,
    output logic [4:0]  trace_dst,
    output logic [31:0] trace_data,
    output logic [31:0] commit_cnt,
    output logic        err_tnew
);

    logic [31:0] regs [32];
    logic        commit;
    logic        not_ready;

    // A write only lands when W really has final data for a real register;
    // reset suppresses it so a write racing reset is dropped.
    always_comb begin
        not_ready = we_w && (tnew_w != 3'd0);
        commit    = !reset && we_w && (dst_w != 5'd0) && (tnew_w == 3'd0);
    end

    // Read one port: $0 is hard-wired to zero, otherwise optionally forward
    // the value being committed this cycle ahead of the array update.
    function automatic logic [31:0] read_port(input logic [4:0] ra);
        logic [31:0] val;
        if (ra == 5'd0) begin
            val = 32'd0;
        end else if ((BYPASS != 0) && commit && (ra == dst_w)) begin
            val = wd_w;
        end else begin
            val = regs[ra];
        end
        return val;
    endfunction

    // Both read ports are purely combinational.
    always_comb begin
        rd1 = read_port(ra1);
        rd2 = read_port(ra2);
    end

    // Register array: cleared on reset, written on commit. Entry 0 is never
    // written, so it stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (commit) begin
            regs[dst_w] <= wd_w;
        end
    end

    // Commit trace: valid pulses for one cycle per commit, payload holds
    // the most recent commit until the next one.
    always_ff @(posedge clk) begin
        if (reset) begin
            trace_valid <= 1'b0;
            trace_pc    <= RESET_PC;
            trace_dst   <= 5'd0;
            trace_data  <= 32'd0;
        end else begin
            trace_valid <= commit;
            if (commit) begin
                trace_pc   <= pc_w;
                trace_dst  <= dst_w;
                trace_data <= wd_w;
            end
        end
    end

    // Commit counter, wraps silently modulo 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            commit_cnt <= 32'd0;
        end else if (commit) begin
            commit_cnt <= commit_cnt + 32'd1;
        end
    end

    // Sticky flag for W delivering a write whose data is not yet ready,
    // regardless of destination; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_tnew <= 1'b0;
        end else if (not_ready) begin
            err_tnew <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: two instances (bypass on / off) share
// stimulus; an array-based reference model predicts every output each cycle.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        we_w;
    logic [31:0] pc_w;
    logic [4:0]  dst_w;
    logic [31:0] wd_w;
    logic [2:0]  tnew_w;
    logic [4:0]  ra1, ra2;

    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic        tv_b, tv_n, err_b, err_n;
    logic [31:0] tpc_b, tpc_n, tdata_b, tdata_n, cnt_b, cnt_n;
    logic [4:0]  tdst_b, tdst_n;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 0;

    // reference model state
    logic [31:0] m_reg [32];
    logic [31:0] m_cnt, m_tpc, m_tdata;
    logic [4:0]  m_tdst;
    logic        m_tv, m_err;

    wb_regfile #(.BYPASS(1), .RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .reset(reset), .we_w(we_w), .pc_w(pc_w), .dst_w(dst_w),
        .wd_w(wd_w), .tnew_w(tnew_w), .ra1(ra1), .ra2(ra2),
        .rd1(rd1_b), .rd2(rd2_b), .trace_valid(tv_b), .trace_pc(tpc_b),
        .trace_dst(tdst_b), .trace_data(tdata_b), .commit_cnt(cnt_b),
        .err_tnew(err_b)
    );

    wb_regfile #(.BYPASS(0), .RESET_PC(32'h0000_3000)) dut0 (
        .clk(clk), .reset(reset), .we_w(we_w), .pc_w(pc_w), .dst_w(dst_w),
        .wd_w(wd_w), .tnew_w(tnew_w), .ra1(ra1), .ra2(ra2),
        .rd1(rd1_n), .rd2(rd2_n), .trace_valid(tv_n), .trace_pc(tpc_n),
        .trace_dst(tdst_n), .trace_data(tdata_n), .commit_cnt(cnt_n),
        .err_tnew(err_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_commit();
        return !reset && we_w && (dst_w != 5'd0) && (tnew_w == 3'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] ra, input bit byp);
        if (ra == 5'd0) return 32'd0;
        if (byp && m_commit() && ra == dst_w) return wd_w;
        return m_reg[ra];
    endfunction

    // reference model: advance on each rising edge from the spec's rules
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
            m_tv = 0; m_tpc = 32'h0000_3000; m_tdst = 0; m_tdata = 0;
            m_cnt = 0; m_err = 0;
        end else begin
            if (we_w && tnew_w != 3'd0) m_err = 1;
            if (m_commit()) begin
                m_reg[dst_w] = wd_w;
                m_tv = 1; m_tpc = pc_w; m_tdst = dst_w; m_tdata = wd_w;
                m_cnt = m_cnt + 32'd1;
            end else begin
                m_tv = 0;
            end
        end
    end

    // compare process: every falling edge once the DUTs are out of reset
    always @(negedge clk) begin
        if (checking) begin
            chk("rd1_byp", rd1_b, m_read(ra1, 1));
            chk("rd2_byp", rd2_b, m_read(ra2, 1));
            chk("rd1_nobyp", rd1_n, m_read(ra1, 0));
            chk("rd2_nobyp", rd2_n, m_read(ra2, 0));
            chk("trace_valid", {31'd0, tv_b}, {31'd0, m_tv});
            chk("trace_valid0", {31'd0, tv_n}, {31'd0, m_tv});
            chk("trace_pc", tpc_b, m_tpc);
            chk("trace_dst", {27'd0, tdst_b}, {27'd0, m_tdst});
            chk("trace_data", tdata_b, m_tdata);
            chk("commit_cnt", cnt_b, m_cnt);
            chk("commit_cnt0", cnt_n, m_cnt);
            chk("err_tnew", {31'd0, err_b}, {31'd0, m_err});
            chk("err_tnew0", {31'd0, err_n}, {31'd0, m_err});
        end
    end

    task automatic set(input logic rst, input logic we, input logic [31:0] pc,
                       input logic [4:0] dst, input logic [31:0] wd,
                       input logic [2:0] tn, input logic [4:0] a1, input logic [4:0] a2);
        reset = rst; we_w = we; pc_w = pc; dst_w = dst; wd_w = wd;
        tnew_w = tn; ra1 = a1; ra2 = a2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        set(0, 0, 32'd0, 5'd0, 32'd0, 3'd0, 5'd0, 5'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        set(1, 0, 32'd0, 5'd0, 32'd0, 3'd0, 5'd0, 5'd0);
        tick(); tick();
        checking = 1;
        chk("reset_trace_pc", tpc_b, 32'h0000_3000);
        chk("reset_cnt", cnt_b, 32'd0);
        chk("reset_tv", {31'd0, tv_b}, 32'd0);
        chk("reset_err", {31'd0, err_b}, 32'd0);

        // basic commit
        set(0, 1, 32'h0000_3004, 5'd5, 32'hDEAD_BEEF, 3'd0, 5'd0, 5'd0);
        tick();
        idle(); ra1 = 5'd5; #1;
        chk("basic_tv", {31'd0, tv_b}, 32'd1);
        chk("basic_dst", {27'd0, tdst_b}, 32'd5);
        chk("basic_pc", tpc_b, 32'h0000_3004);
        chk("basic_cnt", cnt_b, 32'd1);
        chk("basic_rd1", rd1_b, 32'hDEAD_BEEF);
        chk("basic_rd1_nobyp", rd1_n, 32'hDEAD_BEEF);
        tick();

        // $0 protection
        set(0, 1, 32'h0000_3008, 5'd0, 32'h0000_1234, 3'd0, 5'd0, 5'd0);
        #1 chk("zero_rd1", rd1_b, 32'd0);
        tick();
        idle(); #1;
        chk("zero_tv", {31'd0, tv_b}, 32'd0);
        chk("zero_cnt", cnt_b, 32'd1);

        // bypass vs plain read
        set(0, 1, 32'h0000_300C, 5'd7, 32'hA5A5_A5A5, 3'd0, 5'd7, 5'd7);
        #1;
        chk("byp_rd1", rd1_b, 32'hA5A5_A5A5);
        chk("byp_rd2", rd2_b, 32'hA5A5_A5A5);
        chk("nobyp_rd1_pre", rd1_n, 32'd0);
        chk("nobyp_rd2_pre", rd2_n, 32'd0);
        tick();
        idle(); ra1 = 5'd7; ra2 = 5'd7; #1;
        chk("nobyp_rd1_post", rd1_n, 32'hA5A5_A5A5);
        chk("nobyp_rd2_post", rd2_n, 32'hA5A5_A5A5);

        // not-ready data
        set(0, 1, 32'h0000_3010, 5'd3, 32'h0000_FFFF, 3'd1, 5'd3, 5'd0);
        tick();
        idle(); ra1 = 5'd3; #1;
        chk("nr_err", {31'd0, err_b}, 32'd1);
        chk("nr_tv", {31'd0, tv_b}, 32'd0);
        chk("nr_reg3", rd1_b, 32'd0);
        for (int i = 0; i < 10; i++) tick();
        chk("nr_err_sticky", {31'd0, err_b}, 32'd1);

        // reset mid-stream
        for (int i = 0; i < 3; i++) begin
            set(0, 1, 32'h0000_3020, 5'd8, 32'h0000_0011, 3'd0, 5'd0, 5'd0);
            tick();
        end
        set(1, 1, 32'h0000_3024, 5'd9, 32'h0000_0099, 3'd0, 5'd8, 5'd9);
        #1 chk("rst_rd_preclear", rd1_b, 32'h0000_0011);
        tick();
        idle(); ra1 = 5'd9; ra2 = 5'd8; #1;
        chk("rst_cnt", cnt_b, 32'd0);
        chk("rst_pc", tpc_b, 32'h0000_3000);
        chk("rst_err", {31'd0, err_b}, 32'd0);
        chk("rst_reg9", rd1_b, 32'd0);
        chk("rst_reg8", rd2_b, 32'd0);

        // back-to-back commits
        for (int i = 1; i <= 4; i++) begin
            set(0, 1, 32'h0000_3100 + 32'(i * 4), 5'(i), 32'h100 + 32'(i), 3'd0, 5'd0, 5'd0);
            tick();
            chk("b2b_tv", {31'd0, tv_b}, 32'd1);
        end
        idle(); #1;
        chk("b2b_cnt", cnt_b, 32'd4);

        // counter wrap
        force dut.commit_cnt = 32'hFFFF_FFFF;
        force dut0.commit_cnt = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.commit_cnt;
        release dut0.commit_cnt;
        tick();
        set(0, 1, 32'h0000_3200, 5'd10, 32'h0000_0AAA, 3'd0, 5'd0, 5'd0);
        tick();
        idle(); #1;
        chk("wrap_cnt", cnt_b, 32'd0);
        chk("wrap_cnt0", cnt_n, 32'd0);

        // randomized traffic checked by the model each cycle
        for (int i = 0; i < 400; i++) begin
            logic [4:0] d;
            d = 5'($urandom_range(0, 31));
            set(($urandom_range(0, 39) == 0),
                ($urandom_range(0, 9) < 7),
                $urandom(),
                d,
                $urandom(),
                ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
                ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31)),
                ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31)));
            tick();
        end
        idle();
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
